// File: rtl/int_div_pkg.sv
// Shared constants and helpers for the iterative 32-bit divider.
// Covers op encodings, FSM states and the result-selection function.
package int_div_pkg;

  localparam int DIV_ITERATIONS = 32;
  localparam int CNT_W          = 5;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } div_state_e;

  function automatic logic [31:0] neg32(
    input logic [31:0] x
  );
    return ~x + 32'd1;
  endfunction

  // Shared by the fixup state and the early-out path so that
  // both builds produce bit-identical special-case results.
  function automatic logic [31:0] div_result(
    input logic [1:0]  op,
    input logic [31:0] quo,
    input logic [31:0] rem,
    input logic        neg_q,
    input logic        neg_r,
    input logic        dz,
    input logic        ovf,
    input logic [31:0] dvd
  );
    logic is_rem;
    is_rem = op[1];
    if (dz)
      return is_rem ? dvd : DIV_ZERO_QUOT;
    if (ovf)
      return is_rem ? 32'd0 : INT_MIN;
    if (is_rem)
      return neg_r ? neg32(rem) : rem;
    return neg_q ? neg32(quo) : quo;
  endfunction

endpackage

// File: rtl/cla_adder_32.sv
// 32-bit carry-lookahead adder/subtractor.
// 4-bit lookahead groups; group carries ripple between groups.
module cla_adder_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sub_i,
  output logic [31:0] sum_o,
  output logic        co_o
);

  logic [31:0] bx;
  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign bx = b_i ^ {32{sub_i}};
  assign g  = a_i & bx;
  assign p  = a_i ^ bx;

  // Carry lookahead inside each nibble, group carry out.
  always_comb begin
    c    = '0;
    c[0] = sub_i;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k]
               | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k]
                  & c[4*k]);
      c[4*k+4] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1]
                  & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1]
                  & p[4*k] & c[4*k]);
    end
  end

  assign sum_o = p ^ c[31:0];
  assign co_o  = c[32];

endmodule

// File: rtl/int_div_32_step.sv
// One restoring-division iteration (combinational).
// The partial remainder is always below the divisor, so 32 bits hold it.
module div_step (
  input  logic [31:0] rem_i,
  input  logic        bit_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic        q_o
);

  logic [32:0] shifted;
  logic [31:0] diff;
  logic        no_borrow;

  assign shifted = {rem_i, bit_i};

  cla_adder_32 u_sub (
    .a_i   (shifted[31:0]),
    .b_i   (divisor_i),
    .sub_i (1'b1),
    .sum_o (diff),
    .co_o  (no_borrow)
  );

  // Bit 32 set means the 33-bit value already exceeds any divisor.
  assign q_o   = shifted[32] | no_borrow;
  assign rem_o = q_o ? diff : shifted[31:0];

endmodule

// File: rtl/int_div_32.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Optional INT_DIV_EARLY_OUT_EN resolves /0 and overflow in IDLE.
module int_div_32
  import int_div_pkg::*;
#(
  parameter int OPERAND_SIZE = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic [1:0]              op_i,
  input  logic [OPERAND_SIZE-1:0] dividend_i,
  input  logic [OPERAND_SIZE-1:0] divisor_i,
  output logic                    busy_o,
  output logic                    valid_o,
  output logic [OPERAND_SIZE-1:0] result_o
);

  div_state_e state;
  div_state_e state_nxt;

  logic [CNT_W-1:0] count;
  logic [1:0]       op_q;
  logic [31:0]      dvd_q;
  logic [31:0]      dsr_q;
  logic [31:0]      quo_q;
  logic [31:0]      rem_q;
  logic [31:0]      orig_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic             dz_q;
  logic             ovf_q;

  logic        sgn_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        dz_in;
  logic        ovf_in;
  logic        accept;
  logic        early;
  logic        last;
  logic [31:0] step_rem;
  logic        step_q;
  logic [31:0] fix_res;
  logic [31:0] early_res;

  assign sgn_op = ~op_i[0];
  assign a_neg  = sgn_op & dividend_i[31];
  assign b_neg  = sgn_op & divisor_i[31];
  assign a_mag  = a_neg ? neg32(dividend_i) : dividend_i;
  assign b_mag  = b_neg ? neg32(divisor_i) : divisor_i;
  assign dz_in  = (divisor_i == 32'd0);
  assign ovf_in = sgn_op
                & (dividend_i == INT_MIN)
                & (divisor_i == DIV_ZERO_QUOT);
  assign accept = start_i & (state == IDLE);
  assign last   = (count == CNT_W'(DIV_ITERATIONS - 1));
  assign busy_o = (state != IDLE);

`ifdef INT_DIV_EARLY_OUT_EN
  assign early = dz_in | ovf_in;
`else
  assign early = 1'b0;
`endif

  div_step u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[31]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  assign fix_res = div_result(op_q, quo_q, rem_q,
                              neg_q_q, neg_r_q,
                              dz_q, ovf_q, orig_q);

  assign early_res = div_result(op_i, 32'd0, 32'd0,
                                1'b0, 1'b0,
                                dz_in, ovf_in, dividend_i);

  // State register, falling-edge like the multiplier pipe.
  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state: IDLE -> CALC (32 steps) -> FIX -> IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept && !early) state_nxt = CALC;
      CALC: if (last) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count    <= '0;
      op_q     <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      orig_q   <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= '0;
    end else begin
      valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept && early) begin
            result_o <= early_res;
            valid_o  <= 1'b1;
          end else if (accept) begin
            count   <= '0;
            op_q    <= op_i;
            dvd_q   <= a_mag;
            dsr_q   <= b_mag;
            quo_q   <= '0;
            rem_q   <= '0;
            orig_q  <= dividend_i;
            neg_q_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
            dz_q    <= dz_in;
            ovf_q   <= ovf_in;
          end
        end
        CALC: begin
          rem_q <= step_rem;
          dvd_q <= {dvd_q[30:0], 1'b0};
          quo_q <= {quo_q[30:0], step_q};
          count <= count + CNT_W'(1);
        end
        FIX: begin
          result_o <= fix_res;
          valid_o  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_div_32.sv
// Scoreboard bench for int_div_32: directed vectors, decoupled monitor.
// Checks result value and the cycle of each valid_o pulse.
module tb_int_div_32;
  import int_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        valid;
  logic [31:0] res;

`ifdef INT_DIV_EARLY_OUT_EN
  localparam int SPC_LAT = 0;
`else
  localparam int SPC_LAT = 33;
`endif

  typedef struct {
    logic [31:0] r;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_valid = 1'b0;

  int_div_32 #(.OPERAND_SIZE(32)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .op_i       (op),
    .dividend_i (a),
    .divisor_i  (b),
    .busy_o     (busy),
    .valid_o    (valid),
    .result_o   (res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (valid) begin
        checks++;
        if (prev_valid) begin
          errors++;
          $display("FAIL valid_width: got 2+ cycles expected 1");
        end
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got %h expected none",
                   res);
        end else begin
          e = sb.pop_front();
          chk(e.name, res, e.r);
          chk({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
        end
      end
      prev_valid = valid;
    end
  end

  task automatic issue_now(input logic [1:0] o,
                           input logic [31:0] x,
                           input logic [31:0] y,
                           input logic [31:0] exp,
                           input int lat,
                           input bit push,
                           input string nm);
    exp_t e;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    if (push) begin
      e.r = exp;
      e.due = cyc + lat + 1;
      e.name = nm;
      sb.push_back(e);
    end
    #2 start = 1'b0;
  endtask

  task automatic issue(input logic [1:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input logic [31:0] exp,
                       input int lat,
                       input bit push,
                       input string nm);
    @(posedge clk);
    #2;
    issue_now(o, x, y, exp, lat, push, nm);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL timeout: got busy=%b pending=%0d expected idle",
               busy, sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin : stim
    int n;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_result", res, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    issue(OP_DIVU, 32'd100, 32'd7, 32'h0000_000E, 33, 1, "divu_100_7");
    wait_done();
    issue(OP_REMU, 32'd100, 32'd7, 32'h0000_0002, 33, 1, "remu_100_7");
    wait_done();
    issue(OP_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD, 33, 1, "div_m7_2");
    wait_done();
    issue(OP_REM, -32'sd7, 32'd2, 32'hFFFF_FFFF, 33, 1, "rem_m7_2");
    wait_done();
    issue(OP_REM, 32'd7, -32'sd2, 32'h0000_0001, 33, 1, "rem_7_m2");
    wait_done();

    issue(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SPC_LAT, 1, "divu_5_0");
    wait_done();
    issue(OP_REMU, 32'd5, 32'd0, 32'h0000_0005, SPC_LAT, 1, "remu_5_0");
    wait_done();
    issue(OP_DIV, -32'sd5, 32'd0, 32'hFFFF_FFFF, SPC_LAT, 1, "div_m5_0");
    wait_done();
    issue(OP_REM, -32'sd5, 32'd0, 32'hFFFF_FFFB, SPC_LAT, 1, "rem_m5_0");
    wait_done();

    issue(OP_DIV, INT_MIN, 32'hFFFF_FFFF, INT_MIN, SPC_LAT, 1, "div_ovf");
    wait_done();
    issue(OP_REM, INT_MIN, 32'hFFFF_FFFF, 32'd0, SPC_LAT, 1, "rem_ovf");
    wait_done();
    issue(OP_DIVU, INT_MIN, 32'hFFFF_FFFF, 32'd0, 33, 1, "divu_ovf_ops");
    wait_done();

    issue(OP_DIVU, 32'd100, 32'd7, 32'h0000_000E, 33, 1, "ignored_start");
    repeat (5) @(posedge clk);
    #2;
    chk("busy_mid_op", 32'(busy), 32'd1);
    start = 1'b1;
    op = OP_DIVU;
    a = 32'd9;
    b = 32'd3;
    @(negedge clk);
    #2 start = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!valid && n < 100);
    if (!valid) begin
      checks++;
      errors++;
      $display("FAIL no_valid: got 0 expected 1");
    end
    #1;
    issue_now(OP_DIVU, 32'd9, 32'd3, 32'h0000_0003, 33, 1, "valid_cycle_start");
    wait_done();

    issue(OP_DIVU, 32'd100, 32'd7, 32'd0, 33, 0, "aborted");
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_result", res, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    issue(OP_DIVU, 32'd9, 32'd3, 32'h0000_0003, 33, 1, "after_reset");
    wait_done();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
